// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcode, instruction-format and constant definitions for the 16-bit CPU
//
// Purpose : Common types for all pipeline stages. Provides the instrOpcode enum,
//           instruction field positions for the R/I/D/CB/B formats, the NOP_INSTR bubble
//           encoding and a B-format branch-offset helper.
// Ports   : none (package)
package cpu_pkg;

   typedef enum logic [3:0] {
      opADD  = 4'h0,
      opADDI = 4'h1,
      opSUB  = 4'h2,
      opSUBI = 4'h3,
      opAND  = 4'h4,
      opORR  = 4'h5,
      opLDUR = 4'h6,
      opSTUR = 4'h7,
      opCBZ  = 4'h8,
      opCBNZ = 4'h9,
      opB    = 4'hA,
      opBL   = 4'hB,
      opHALT = 4'hF
   } instrOpcode;

   // Opcode lives in the top nibble for every format.
   localparam int OPC_HI    = 15;
   localparam int OPC_LO    = 12;

   // R format: op rd, rn, rm
   localparam int R_RD_HI   = 11;
   localparam int R_RD_LO   = 9;
   localparam int R_RN_HI   = 8;
   localparam int R_RN_LO   = 6;
   localparam int R_RM_HI   = 5;
   localparam int R_RM_LO   = 3;

   // I format: op rd, rn, #imm6
   localparam int I_RD_HI   = 11;
   localparam int I_RD_LO   = 9;
   localparam int I_RN_HI   = 8;
   localparam int I_RN_LO   = 6;
   localparam int I_IMM_HI  = 5;
   localparam int I_IMM_LO  = 0;

   // D format: op rt, [rn, #off6]
   localparam int D_RT_HI   = 11;
   localparam int D_RT_LO   = 9;
   localparam int D_RN_HI   = 8;
   localparam int D_RN_LO   = 6;
   localparam int D_OFF_HI  = 5;
   localparam int D_OFF_LO  = 0;

   // CB format: op rt, #off9 (word offset)
   localparam int CB_RT_HI  = 11;
   localparam int CB_RT_LO  = 9;
   localparam int CB_OFF_HI = 8;
   localparam int CB_OFF_LO = 0;

   // B format: op #off12 (signed word offset)
   localparam int B_OFF_HI  = 11;
   localparam int B_OFF_LO  = 0;

   // Bubble encoding: ADD r7, r7, r7 (architecturally harmless).
   localparam logic [15:0] NOP_INSTR = {opADD, 3'd7, 3'd7, 3'd7, 3'd0};

   // Word offset of a B instruction turned into a signed 16-bit byte displacement.
   function automatic logic [15:0] b_offset(input logic [B_OFF_HI-B_OFF_LO:0] off);
      return {{3{off[B_OFF_HI-B_OFF_LO]}}, off, 1'b0};
   endfunction

endpackage

// File: rtl/ifid_reg.sv
// rtl/ifid_reg.sv - IF/ID pipeline register with flush, hold and load
//
// Purpose : Holds the fetched instruction between fetch and decode.
//           flush has priority and turns the slot into a bubble; hold keeps every field;
//           otherwise the incoming instruction is loaded as valid.
// Ports   : clk, reset (async, active-low)
//           flush, hold           control from fetch_stage
//           in_instr/in_pc/in_pred_taken   fetched slot
//           loaded                high in a cycle whose edge loads a valid instruction
//           out_valid/out_instr/out_pc/out_pred_taken   registered IF/ID contents
module ifid_reg
   import cpu_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        flush,
   input  logic        hold,
   input  logic [15:0] in_instr,
   input  logic [15:0] in_pc,
   input  logic        in_pred_taken,
   output logic        loaded,
   output logic        out_valid,
   output logic [15:0] out_instr,
   output logic [15:0] out_pc,
   output logic        out_pred_taken
);

   logic        valid_q, valid_d;
   logic [15:0] instr_q, instr_d;
   logic [15:0] pc_q,    pc_d;
   logic        pred_q,  pred_d;

   always_comb begin
      valid_d = valid_q;
      instr_d = instr_q;
      pc_d    = pc_q;
      pred_d  = pred_q;
      loaded  = 1'b0;
      if (flush) begin
         valid_d = 1'b0;
         instr_d = NOP_INSTR;
         pred_d  = 1'b0;
         // Bubble keeps the slot address purely as a debug aid; it is not architectural.
         pc_d    = in_pc;
      end else if (!hold) begin
         valid_d = 1'b1;
         instr_d = in_instr;
         pc_d    = in_pc;
         pred_d  = in_pred_taken;
         loaded  = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid_q <= 1'b0;
         instr_q <= NOP_INSTR;
         pc_q    <= 16'h0000;
         pred_q  <= 1'b0;
      end else begin
         valid_q <= valid_d;
         instr_q <= instr_d;
         pc_q    <= pc_d;
         pred_q  <= pred_d;
      end
   end

   assign out_valid      = valid_q;
   assign out_instr      = instr_q;
   assign out_pc         = pc_q;
   assign out_pred_taken = pred_q;

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage: PC, next-PC mux, early B resolution, IF/ID
//
// Purpose : Owns the PC and drives the zero-latency instruction memory. Resolves
//           unconditional B branches in fetch (when EARLY_BRANCH), obeys stall, flush and
//           redirect requests, and counts instructions accepted into IF/ID.
// Ports   : clk, reset (async, active-low)
//           addr            byte address to instruction memory (= pc)
//           instr           instruction returned for addr in the same cycle
//           holdPC/holdIFID stall requests
//           redirect_valid/redirect_target   later-stage PC redirect (bit0 ignored)
//           flush_ifid      squash IF/ID
//           ifid_valid/ifid_instr/ifid_pc/ifid_pred_taken   IF/ID register outputs
//           fetch_cnt       wrapping count of valid IF/ID loads
module fetch_stage
   import cpu_pkg::*;
#(
   parameter logic [15:0] RESET_PC     = 16'h0000,
   parameter bit          EARLY_BRANCH = 1'b1,
   parameter int          CNT_W        = 16
) (
   input  logic             clk,
   input  logic             reset,
   output logic [15:0]      addr,
   input  logic [15:0]      instr,
   input  logic             holdPC,
   input  logic             holdIFID,
   input  logic             redirect_valid,
   input  logic [15:0]      redirect_target,
   input  logic             flush_ifid,
   output logic             ifid_valid,
   output logic [15:0]      ifid_instr,
   output logic [15:0]      ifid_pc,
   output logic             ifid_pred_taken,
   output logic [CNT_W-1:0] fetch_cnt
);

   logic [15:0]      pc_q, pc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic        is_b;
   logic [15:0] b_tgt;
   logic        stall;
   logic        ifid_flush;
   logic        ifid_loaded;

   // Next-PC: redirect beats stall beats early branch beats sequential.
   always_comb begin
      is_b  = EARLY_BRANCH && (instr[OPC_HI:OPC_LO] == opB);
      b_tgt = pc_q + b_offset(instr[B_OFF_HI:B_OFF_LO]);
      // holdIFID alone must also freeze the PC or the instruction being fetched is lost.
      stall = holdPC | holdIFID;
      pc_d  = pc_q + 16'd2;
      if (redirect_valid) begin
         pc_d = redirect_target & 16'hFFFE;
      end else if (stall) begin
         pc_d = pc_q;
      end else if (is_b) begin
         pc_d = b_tgt;
      end
   end

   // A holdPC without holdIFID re-fetches the same word next cycle, so this slot is a bubble.
   assign ifid_flush = redirect_valid | flush_ifid | (holdPC & ~holdIFID);

   always_comb begin
      cnt_d = cnt_q + CNT_W'(ifid_loaded);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc_q  <= RESET_PC & 16'hFFFE;
         cnt_q <= '0;
      end else begin
         pc_q  <= pc_d;
         cnt_q <= cnt_d;
      end
   end

   ifid_reg u_ifid_reg (
      .clk            (clk),
      .reset          (reset),
      .flush          (ifid_flush),
      .hold           (holdIFID),
      .in_instr       (instr),
      .in_pc          (pc_q),
      .in_pred_taken  (is_b),
      .loaded         (ifid_loaded),
      .out_valid      (ifid_valid),
      .out_instr      (ifid_instr),
      .out_pc         (ifid_pc),
      .out_pred_taken (ifid_pred_taken)
   );

   assign addr      = pc_q;
   assign fetch_cnt = cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - self-checking bench for fetch_stage (early-branch and sequential-B builds)
module tb_fetch_stage;
   import cpu_pkg::*;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic        holdPC, holdIFID, redirect_valid, flush_ifid;
   logic [15:0] redirect_target;

   logic [15:0] mem [0:32767];

   logic [15:0] addr_a, instr_a, ifid_instr_a, ifid_pc_a, cnt_a;
   logic        ifid_valid_a, pred_a;
   logic [15:0] addr_b, instr_b, ifid_instr_b, ifid_pc_b, cnt_b;
   logic        ifid_valid_b, pred_b;

   assign instr_a = mem[addr_a[15:1]];
   assign instr_b = mem[addr_b[15:1]];

   fetch_stage #(.RESET_PC(16'h0000), .EARLY_BRANCH(1'b1), .CNT_W(16)) dut_a (
      .clk(clk), .reset(reset), .addr(addr_a), .instr(instr_a),
      .holdPC(holdPC), .holdIFID(holdIFID), .redirect_valid(redirect_valid),
      .redirect_target(redirect_target), .flush_ifid(flush_ifid),
      .ifid_valid(ifid_valid_a), .ifid_instr(ifid_instr_a), .ifid_pc(ifid_pc_a),
      .ifid_pred_taken(pred_a), .fetch_cnt(cnt_a)
   );

   fetch_stage #(.RESET_PC(16'h0000), .EARLY_BRANCH(1'b0), .CNT_W(16)) dut_b (
      .clk(clk), .reset(reset), .addr(addr_b), .instr(instr_b),
      .holdPC(holdPC), .holdIFID(holdIFID), .redirect_valid(redirect_valid),
      .redirect_target(redirect_target), .flush_ifid(flush_ifid),
      .ifid_valid(ifid_valid_b), .ifid_instr(ifid_instr_b), .ifid_pc(ifid_pc_b),
      .ifid_pred_taken(pred_b), .fetch_cnt(cnt_b)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: index 0 = early-branch build, index 1 = sequential-B build.
   logic [15:0] m_pc [2];
   logic [15:0] m_ipc [2];
   logic [15:0] m_instr [2];
   logic [15:0] m_cnt [2];
   logic        m_v [2];
   logic        m_pt [2];

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_pc[i] = 16'h0000; m_ipc[i] = 16'h0000; m_instr[i] = NOP_INSTR;
         m_cnt[i] = 16'h0000; m_v[i] = 1'b0; m_pt[i] = 1'b0;
      end
   endtask

   task automatic model_step();
      for (int i = 0; i < 2; i++) begin
         logic [15:0] ins;
         logic        isb;
         int          off, p, npc;
         ins = mem[m_pc[i][15:1]];
         isb = (i == 0) && (ins[15:12] == opB);
         off = ins[11] ? int'(ins[11:0]) - 4096 : int'(ins[11:0]);
         p   = int'(m_pc[i]);
         if (redirect_valid)           npc = int'(redirect_target) & 32'hFFFE;
         else if (holdPC || holdIFID)  npc = p;
         else if (isb)                 npc = (p + 2 * off) & 32'hFFFF;
         else                          npc = (p + 2) & 32'hFFFF;
         if (redirect_valid || flush_ifid || (holdPC && !holdIFID)) begin
            m_v[i] = 1'b0; m_instr[i] = NOP_INSTR; m_pt[i] = 1'b0;
         end else if (!holdIFID) begin
            m_v[i] = 1'b1; m_instr[i] = ins; m_ipc[i] = m_pc[i]; m_pt[i] = isb;
            m_cnt[i] = m_cnt[i] + 16'd1;
         end
         m_pc[i] = npc[15:0];
      end
   endtask

   task automatic check_all();
      chk("addr_a",  addr_a,                m_pc[0]);
      chk("valid_a", 16'(ifid_valid_a),     16'(m_v[0]));
      chk("instr_a", ifid_instr_a,          m_instr[0]);
      chk("pred_a",  16'(pred_a),           16'(m_pt[0]));
      chk("cnt_a",   cnt_a,                 m_cnt[0]);
      if (m_v[0]) chk("ifpc_a", ifid_pc_a,  m_ipc[0]);
      chk("addr_b",  addr_b,                m_pc[1]);
      chk("valid_b", 16'(ifid_valid_b),     16'(m_v[1]));
      chk("instr_b", ifid_instr_b,          m_instr[1]);
      chk("pred_b",  16'(pred_b),           16'(m_pt[1]));
      chk("cnt_b",   cnt_b,                 m_cnt[1]);
      if (m_v[1]) chk("ifpc_b", ifid_pc_b,  m_ipc[1]);
   endtask

   // Called just after a falling edge: drive, advance model, clock, compare.
   task automatic cycle(input logic hp, input logic hi, input logic rv,
                        input logic [15:0] rt, input logic fl);
      holdPC = hp; holdIFID = hi; redirect_valid = rv; redirect_target = rt; flush_ifid = fl;
      model_step();
      @(posedge clk);
      @(negedge clk);
      check_all();
   endtask

   task automatic random_cycles(input int n);
      for (int k = 0; k < n; k++) begin
         cycle(($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
               ($urandom_range(0, 15) == 0), 16'($urandom), ($urandom_range(0, 15) == 0));
      end
   endtask

   initial begin
      reset = 1'b0;
      holdPC = 1'b0; holdIFID = 1'b0; redirect_valid = 1'b0; flush_ifid = 1'b0;
      redirect_target = 16'h0000;
      for (int w = 0; w < 32768; w++) begin
         logic [15:0] r;
         r = 16'($urandom);
         if ($urandom_range(0, 5) == 0) r[15:12] = opB;
         mem[w] = r;
      end
      mem[0] = 16'h1241;          // ADDI r1, r1, #1
      mem[1] = 16'h1482;          // ADDI r2, r2, #2
      mem[2] = 16'h3283;          // SUBI r1, r2, #3
      mem[3] = 16'h0650;          // ADD  r3, r1, r2
      mem[4] = 16'hAFFC;          // B    #-4  (byte -8)
      mem[32767] = NOP_INSTR;
      model_reset();

      // Reset held 3 cycles.
      @(negedge clk);
      check_all();
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("rel_addr", addr_a, 16'h0000);
      chk("rel_valid", 16'(ifid_valid_a), 16'h0000);

      // Straight-line code then the early B at 8.
      for (int k = 0; k < 4; k++) cycle(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
      chk("seq_addr", addr_a, 16'h0008);
      chk("seq_cnt", cnt_a, 16'h0004);
      cycle(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
      chk("b_addr", addr_a, 16'h0000);
      chk("b_ifpc", ifid_pc_a, 16'h0008);
      chk("b_pred", 16'(pred_a), 16'h0001);
      chk("nb_addr", addr_b, 16'h000A);
      chk("nb_pred", 16'(pred_b), 16'h0000);

      // holdPC for two cycles at 4.
      cycle(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
      cycle(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
      for (int k = 0; k < 2; k++) begin
         cycle(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
         chk("hold_addr", addr_a, 16'h0004);
         chk("hold_bubble", 16'(ifid_valid_a), 16'h0000);
      end
      cycle(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
      chk("hold_rel_ifpc", ifid_pc_a, 16'h0004);

      // Redirect beats holdIFID at 6.
      chk("pre_redir_addr", addr_a, 16'h0006);
      cycle(1'b0, 1'b1, 1'b1, 16'h0021, 1'b0);
      chk("redir_addr", addr_a, 16'h0020);
      chk("redir_bubble", 16'(ifid_valid_a), 16'h0000);

      // PC wrap at the top of memory.
      cycle(1'b0, 1'b0, 1'b1, 16'hFFFE, 1'b0);
      chk("wrap_top", addr_a, 16'hFFFE);
      cycle(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
      chk("wrap_zero", addr_a, 16'h0000);
      chk("wrap_ifpc", ifid_pc_a, 16'hFFFE);

      random_cycles(400);

      // Asynchronous reset mid-cycle: outputs must clear before any edge.
      @(posedge clk);
      #2;
      reset = 1'b0;
      #1;
      chk("areset_addr", addr_a, 16'h0000);
      chk("areset_valid", 16'(ifid_valid_a), 16'h0000);
      chk("areset_instr", ifid_instr_a, NOP_INSTR);
      chk("areset_cnt", cnt_a, 16'h0000);
      chk("areset_addr_b", addr_b, 16'h0000);
      model_reset();
      @(negedge clk);
      check_all();
      reset = 1'b1;
      random_cycles(300);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
